// File: rtl/ts_pkg.sv
// Shared constants, FSM encoding and BCD helpers for the timestamp ASCII encoder.
package ts_pkg;

  localparam int TS_WIDTH   = 32;
  localparam int NUM_DIGITS = 10;
  localparam int BCD_W      = 4 * NUM_DIGITS;
  localparam logic [7:0] ASCII_ZERO = 8'h30;

  typedef enum logic [1:0] {IDLE, CONV, SEND, TERM} state_t;

  // Double-dabble correction: every nibble >= 5 gets +3 before the next shift.
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    return r;
  endfunction

  // idx 0 selects the most significant digit.
  function automatic logic [3:0] digit_at(input logic [BCD_W-1:0] b, input logic [3:0] idx);
    logic [3:0] d;
    d = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (idx == 4'(NUM_DIGITS-1-i)) d = b[4*i +: 4];
    return d;
  endfunction

  // Index of the first nonzero digit; an all-zero value still yields the last digit.
  function automatic logic [3:0] first_nz(input logic [BCD_W-1:0] b);
    logic [3:0] idx;
    idx = 4'(NUM_DIGITS-1);
    for (int i = 0; i < NUM_DIGITS; i++)
      if (b[4*i +: 4] != 4'd0) idx = 4'(NUM_DIGITS-1-i);
    return idx;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter, one bit per cycle, MSB first.
// The first bit shifts in on the start edge, so done pulses 31 cycles later with bcd final.
module bin2bcd_seq
  import ts_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [TS_WIDTH-1:0] din,
  output logic                done,
  output logic [BCD_W-1:0]    bcd
);

  logic [TS_WIDTH-1:0]         sh;
  logic [$clog2(TS_WIDTH)-1:0] cnt;
  logic                        run;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bcd  <= '0;
      sh   <= '0;
      cnt  <= '0;
      run  <= 1'b0;
      done <= 1'b0;
    end else if (start) begin
      bcd  <= {{(BCD_W-1){1'b0}}, din[TS_WIDTH-1]};
      sh   <= din << 1;
      cnt  <= 1;
      run  <= 1'b1;
      done <= 1'b0;
    end else if (run) begin
      bcd <= (add3(bcd) << 1) | {{(BCD_W-1){1'b0}}, sh[TS_WIDTH-1]};
      sh  <= sh << 1;
      cnt <= cnt + 1'b1;
      if (cnt == $clog2(TS_WIDTH)'(TS_WIDTH-1)) begin
        run  <= 1'b0;
        done <= 1'b1;
      end
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: rtl/ts_ascii_encoder.sv
// Timestamp to ASCII decimal byte stream with valid/ready handshake and terminator.
// Optional TS_ZERO_SUPPRESS_EN drops leading zero digits (value 0 still sends "0").
module ts_ascii_encoder
  import ts_pkg::*;
#(
  parameter logic [7:0] TERM_CHAR = 8'h0A
) (
  input  logic                i_clk,
  input  logic                i_res_n,
  input  logic                i_start,
  input  logic [TS_WIDTH-1:0] i_ts_val,
  output logic                o_busy,
  output logic [7:0]          o_tx_data,
  output logic                o_tx_valid,
  input  logic                i_tx_ready
);

  state_t             state, state_nx;
  logic [3:0]         idx, idx_nx;
  logic               conv_start, conv_done, xfer;
  logic [BCD_W-1:0]   bcd;
  logic [3:0]         digit;

  // Starts are only forwarded from IDLE, so the converter's latched value is safe.
  bin2bcd_seq u_conv (
    .clk   (i_clk),
    .rst_n (i_res_n),
    .start (conv_start),
    .din   (i_ts_val),
    .done  (conv_done),
    .bcd   (bcd)
  );

  always_ff @(posedge i_clk) begin
    if (!i_res_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  assign digit = digit_at(bcd, idx);
  assign xfer  = o_tx_valid && i_tx_ready;

  always_comb begin
    state_nx   = state;
    idx_nx     = idx;
    conv_start = 1'b0;
    o_busy     = 1'b1;
    o_tx_valid = 1'b0;
    o_tx_data  = 8'h00;
    case (state)
      IDLE: begin
        o_busy = 1'b0;
        if (i_start) begin
          conv_start = 1'b1;
          state_nx   = CONV;
        end
      end
      CONV: begin
        if (conv_done) begin
          state_nx = SEND;
`ifdef TS_ZERO_SUPPRESS_EN
          idx_nx = first_nz(bcd);
`else
          idx_nx = '0;
`endif
        end
      end
      SEND: begin
        o_tx_valid = 1'b1;
        o_tx_data  = ASCII_ZERO + {4'd0, digit};
        if (xfer) begin
          if (idx == 4'(NUM_DIGITS-1)) state_nx = TERM;
          else                         idx_nx   = idx + 4'd1;
        end
      end
      TERM: begin
        o_tx_valid = 1'b1;
        o_tx_data  = TERM_CHAR;
        if (xfer) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ts_ascii_encoder.sv
// Scoreboard bench for ts_ascii_encoder: expected bytes queued at start, popped on each transfer.
module tb_ts_ascii_encoder;

  logic        i_clk = 1'b0;
  logic        i_res_n;
  logic        i_start;
  logic [31:0] i_ts_val;
  logic        o_busy;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready;

  int compared   = 0;
  int mismatched = 0;
  int acc_cnt    = 0;

  logic [7:0] q[$];
  bit   rnd_ready = 1'b0;
  bit   stall_chk = 1'b1;

  ts_ascii_encoder #(.TERM_CHAR(8'h0A)) dut (
    .i_clk      (i_clk),
    .i_res_n    (i_res_n),
    .i_start    (i_start),
    .i_ts_val   (i_ts_val),
    .o_busy     (o_busy),
    .o_tx_data  (o_tx_data),
    .o_tx_valid (o_tx_valid),
    .i_tx_ready (i_tx_ready)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference decimal expansion; returns the number of digits emitted.
  task automatic push_exp(input logic [31:0] v, output int ndig);
    int d[10];
    longint x;
    int first;
    x = v;
    for (int i = 9; i >= 0; i--) begin
      d[i] = int'(x % 10);
      x = x / 10;
    end
    first = 0;
`ifdef TS_ZERO_SUPPRESS_EN
    while (first < 9 && d[first] == 0) first++;
`endif
    for (int i = first; i < 10; i++) q.push_back(8'h30 + 8'(d[i]));
    q.push_back(8'h0A);
    ndig = 10 - first;
  endtask

  // Ready randomizer for stall testing.
  initial begin
    forever begin
      @(negedge i_clk);
      if (rnd_ready) i_tx_ready = 1'($urandom_range(0, 1));
    end
  end

  // Transfer monitor: scoreboard pop and hold-while-stalled check.
  initial begin
    logic       pv, pr;
    logic [7:0] pd;
    pv = 1'b0; pr = 1'b0; pd = 8'h00;
    forever begin
      @(negedge i_clk);
      #1;
      if (stall_chk && pv && !pr) begin
        check("stall_valid", 32'(o_tx_valid), 32'd1);
        check("stall_data", 32'(o_tx_data), 32'(pd));
      end
      if (o_tx_valid && i_tx_ready) begin
        if (q.size() == 0) check("unexpected_byte", 32'(o_tx_data), 32'hFFFF_FFFF);
        else check("byte", 32'(o_tx_data), 32'(q.pop_front()));
        acc_cnt++;
      end
      pv = o_tx_valid; pr = i_tx_ready; pd = o_tx_data;
    end
  end

  // Called at a negedge; returns at the first negedge back in IDLE.
  task automatic do_op(input logic [31:0] v, input bit chk_busy, input int inject_cyc);
    int ndig, cyc, busy_cnt, first_vld;
    push_exp(v, ndig);
    i_start = 1'b1; i_ts_val = v;
    @(negedge i_clk);
    i_start = 1'b0; i_ts_val = 32'hDEAD_BEEF;
    cyc = 1; busy_cnt = 0; first_vld = -1;
    while (cyc < 2000) begin
      if (cyc == inject_cyc)     begin i_start = 1'b1; i_ts_val = 32'd99; end
      if (cyc == inject_cyc + 1) i_start = 1'b0;
      #2;
      if (o_busy) busy_cnt++;
      if (o_tx_valid && first_vld < 0) first_vld = cyc;
      if (!o_busy) break;
      @(negedge i_clk);
      cyc++;
    end
    check("timeout", 32'(cyc < 2000), 32'd1);
    check("first_valid_cycle", 32'(first_vld), 32'd33);
    if (chk_busy) check("busy_cycles", 32'(busy_cnt), 32'(32 + ndig + 1));
    check("queue_drained", 32'(q.size()), 32'd0);
  endtask

  initial begin
    int base, t;
    i_res_n = 1'b0; i_start = 1'b0; i_ts_val = '0; i_tx_ready = 1'b1;
    repeat (3) @(negedge i_clk);
    #2;
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_valid", 32'(o_tx_valid), 32'd0);
    check("rst_data", 32'(o_tx_data), 32'd0);
    @(negedge i_clk);
    i_res_n = 1'b1;
    @(negedge i_clk);

    do_op(32'd1234, 1'b1, -1);
    do_op(32'hFFFF_FFFF, 1'b1, -1);
    do_op(32'd0, 1'b1, -1);
    do_op(32'd1000, 1'b1, -1);

    rnd_ready = 1'b1;
    do_op(32'd57, 1'b0, -1);
    rnd_ready = 1'b0; i_tx_ready = 1'b1;
    @(negedge i_clk);

    // A start during CONV must be ignored; the next op starts on the first IDLE cycle.
    do_op(32'd2024, 1'b1, 5);
    do_op(32'd7, 1'b1, -1);

    // Reset after three accepted bytes.
    base = acc_cnt;
    push_exp(32'd1234, t);
    i_start = 1'b1; i_ts_val = 32'd1234;
    @(negedge i_clk);
    i_start = 1'b0;
    t = 0;
    while (acc_cnt < base + 3 && t < 200) begin
      @(negedge i_clk); #2; t++;
    end
    check("reset_wait", 32'(t < 200), 32'd1);
    @(negedge i_clk);
    stall_chk = 1'b0; i_tx_ready = 1'b0; i_res_n = 1'b0;
    @(negedge i_clk);
    #2;
    check("midrst_valid", 32'(o_tx_valid), 32'd0);
    check("midrst_busy", 32'(o_busy), 32'd0);
    check("midrst_data", 32'(o_tx_data), 32'd0);
    q.delete();
    i_res_n = 1'b1; i_tx_ready = 1'b1;
    t = 0;
    repeat (60) begin
      @(negedge i_clk); #2;
      if (o_tx_valid || o_busy) t++;
    end
    check("no_bytes_after_reset", 32'(t), 32'd0);
    check("bytes_before_reset", 32'(acc_cnt - base), 32'd3);
    stall_chk = 1'b1;

    do_op(32'd305419896, 1'b1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
